// File: rtl/bcd_time_pkg.sv
// bcd_time_pkg: shared BCD digit limits and the hh:mm load validity check
package bcd_time_pkg;
   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] MIN1_MAX = 4'd5;
   localparam logic [BCD_W-1:0] DIG_MAX = 4'd9;
   localparam logic [BCD_W-1:0] HOUR1_MAX = 4'd2;
   localparam logic [BCD_W-1:0] HOUR0_MAX_AT_20 = 4'd3;

   function automatic logic is_valid_hhmm(input logic [BCD_W-1:0] h1, h0, m1, m0);
      return h1 <= HOUR1_MAX && h0 <= DIG_MAX && !(h1 == HOUR1_MAX && h0 > HOUR0_MAX_AT_20)
         && m1 <= MIN1_MAX && m0 <= DIG_MAX;
   endfunction
endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: single BCD digit, counts 0..MAX with a combinational carry on wrap
module bcd_digit_counter
   import bcd_time_pkg::*;
#(
   parameter logic [BCD_W-1:0] MAX = DIG_MAX
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             load,
   input  logic [BCD_W-1:0] ld_val,
   output logic [BCD_W-1:0] q,
   output logic             carry
);
   assign carry = inc && q == MAX;

   always_ff @(posedge clk or posedge reset)
      if (reset) q <= '0;
      else if (load) q <= ld_val;
      else if (inc) q <= q == MAX ? '0 : q + 1'b1;
endmodule

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 24-hour BCD hh:mm clock advanced by sec_tick, with validated parallel load
module bcd_time_counter
   import bcd_time_pkg::*;
#(
   parameter int SEC_PER_MIN = 60,
   parameter int SEC_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sec_tick,
   input  logic             load,
   input  logic [BCD_W-1:0] ld_hour1,
   input  logic [BCD_W-1:0] ld_hour0,
   input  logic [BCD_W-1:0] ld_min1,
   input  logic [BCD_W-1:0] ld_min0,
   output logic [BCD_W-1:0] curHour1,
   output logic [BCD_W-1:0] curHour0,
   output logic [BCD_W-1:0] curMin1,
   output logic [BCD_W-1:0] curMin0,
   output logic             min_tick,
   output logic             load_err
);
   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);
   logic [SEC_W-1:0] sec;
   logic ld_ok, ld_go, min_adv, m0_carry, hr_inc, last_hr;

   assign ld_ok = is_valid_hhmm(ld_hour1, ld_hour0, ld_min1, ld_min0);
   assign ld_go = load && ld_ok;
   assign min_adv = sec_tick && !load && sec == SEC_LAST;
   assign last_hr = curHour1 == HOUR1_MAX && curHour0 == HOUR0_MAX_AT_20;

   bcd_digit_counter #(.MAX(DIG_MAX)) u_min0 (
      .clk(clk), .reset(reset), .inc(min_adv), .load(ld_go),
      .ld_val(ld_min0), .q(curMin0), .carry(m0_carry)
   );

   bcd_digit_counter #(.MAX(MIN1_MAX)) u_min1 (
      .clk(clk), .reset(reset), .inc(m0_carry), .load(ld_go),
      .ld_val(ld_min1), .q(curMin1), .carry(hr_inc)
   );

   // Hours stay here because 23 wraps to 00 rather than at the digit maxima
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sec <= '0;
         curHour1 <= '0;
         curHour0 <= '0;
         min_tick <= 1'b0;
         load_err <= 1'b0;
      end else begin
         min_tick <= min_adv;
         load_err <= load && !ld_ok;
         if (ld_go) begin
            sec <= '0;
            curHour1 <= ld_hour1;
            curHour0 <= ld_hour0;
         end else if (sec_tick && !load) begin
            sec <= min_adv ? '0 : sec + 1'b1;
            if (hr_inc) begin
               curHour0 <= (last_hr || curHour0 == DIG_MAX) ? '0 : curHour0 + 1'b1;
               curHour1 <= last_hr ? '0 : curHour0 == DIG_MAX ? curHour1 + 1'b1 : curHour1;
            end
         end
      end
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: scoreboard bench against a minutes-of-day reference model
module tb_bcd_time_counter;
   localparam int SPM = 4;
   logic clk = 1'b0;
   logic reset, sec_tick, load;
   logic [3:0] ld_hour1, ld_hour0, ld_min1, ld_min0;
   logic [3:0] curHour1, curHour0, curMin1, curMin0;
   logic min_tick, load_err;
   int checks = 0, failures = 0;
   int mins = 0, secs = 0;
   logic [17:0] sb[$];

   bcd_time_counter #(.SEC_PER_MIN(SPM), .SEC_W(2)) dut (
      .clk(clk), .reset(reset), .sec_tick(sec_tick), .load(load),
      .ld_hour1(ld_hour1), .ld_hour0(ld_hour0), .ld_min1(ld_min1), .ld_min0(ld_min0),
      .curHour1(curHour1), .curHour0(curHour0), .curMin1(curMin1), .curMin0(curMin0),
      .min_tick(min_tick), .load_err(load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] expect_vec(input int m, input bit mt, input bit le);
      int hh = m / 60, mm = m % 60;
      return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), mt, le};
   endfunction

   // One clock: drive on negedge, predict, sample 1 time unit after the posedge
   task automatic step(input string tag, input bit t, input bit l,
                       input int h1, input int h0, input int m1, input int m0);
      bit mt = 0, le = 0;
      @(negedge clk);
      sec_tick = t; load = l;
      ld_hour1 = 4'(h1); ld_hour0 = 4'(h0); ld_min1 = 4'(m1); ld_min0 = 4'(m0);
      if (l) begin
         if (h0 <= 9 && m1 <= 5 && m0 <= 9 && h1 * 10 + h0 < 24) begin
            mins = (h1 * 10 + h0) * 60 + m1 * 10 + m0;
            secs = 0;
         end else le = 1;
      end else if (t) begin
         if (secs == SPM - 1) begin
            secs = 0;
            mins = (mins + 1) % 1440;
            mt = 1;
         end else secs++;
      end
      sb.push_back(expect_vec(mins, mt, le));
      @(posedge clk);
      #1;
      sec_tick = 0; load = 0;
      check(tag, {14'd0, curHour1, curHour0, curMin1, curMin0, min_tick, load_err}, {14'd0, sb.pop_front()});
   endtask

   task automatic tick(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1, 0, 0, 0, 0, 0);
   endtask

   task automatic ld(input string tag, input int h1, input int h0, input int m1, input int m0);
      step(tag, 0, 1, h1, h0, m1, m0);
   endtask

   initial begin
      reset = 1; sec_tick = 0; load = 0;
      ld_hour1 = 0; ld_hour0 = 0; ld_min1 = 0; ld_min0 = 0;
      #12;
      check("reset_out", {curHour1, curHour0, curMin1, curMin0, min_tick, load_err}, 18'd0);
      @(negedge clk); reset = 0;
      step("t1_idle", 0, 0, 0, 0, 0, 0);
      tick("t1_tick", 4);
      step("t1_fall", 0, 0, 0, 0, 0, 0);
      ld("t2_load", 0, 9, 5, 9);
      tick("t2_0959", 4);
      step("t2_fall", 0, 0, 0, 0, 0, 0);
      ld("t3_load", 2, 3, 5, 9);
      tick("t3_wrap", 4);
      ld("t3_load19", 1, 9, 5, 9);
      tick("t3_1959", 4);
      tick("t4_pre", 2);
      ld("t4_bad24", 2, 4, 0, 0);
      ld("t4_bad60", 1, 2, 6, 0);
      ld("t4_bad30", 3, 0, 0, 0);
      ld("t4_badA", 0, 10, 0, 0);
      tick("t4_resume", 4);
      step("t5_ldtick", 1, 1, 0, 9, 2, 5);
      tick("t5_hold", 3);
      tick("t5_adv", 1);
      check("alarm_0926", 32'({curHour1, curHour0, curMin1, curMin0} == 16'h0926), 32'd1);
      tick("t6_pre", 2);
      @(negedge clk); reset = 1;
      #2;
      check("t6_async", {curHour1, curHour0, curMin1, curMin0, min_tick, load_err}, 18'd0);
      mins = 0; secs = 0;
      @(negedge clk); reset = 0;
      tick("t6_after", 4);
      ld("day_load", 2, 2, 5, 8);
      tick("day_run", SPM * 1440 + 8);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
